// File: rtl/axi4_lite_req_manager.sv
// AXI4-Lite manager: one request in flight, registered AXI and response outputs,
// per-transaction timeout with a drain window for late B/R beats.
module axi4_lite_req_manager #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          TIMEOUT    = 64,
  parameter logic [2:0]  PROT       = 3'b001
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_AW,
    S_WR_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_expired;
  logic w_waiting;
  logic w_progress;
  logic w_abort;

  assign w_aw_hs   = r_awvalid & m_awready;
  assign w_w_hs    = r_wvalid & m_wready;
  assign w_ar_hs   = r_arvalid & m_arready;
  assign w_b_hs    = r_bready & m_bvalid;
  assign w_r_hs    = r_rready & m_rvalid;
  assign w_expired = (r_timer >= TMAX);

  // Progress in the current wait state cancels a timeout in that cycle
  always_comb begin
    w_waiting  = 1'b1;
    w_progress = 1'b0;
    unique case (r_state)
      S_WR_AW_W: w_progress = w_aw_hs | w_w_hs;
      S_WR_AW:   w_progress = w_aw_hs;
      S_WR_W:    w_progress = w_w_hs;
      S_WR_B:    w_progress = w_b_hs;
      S_RD_AR:   w_progress = w_ar_hs;
      S_RD_R:    w_progress = w_r_hs;
      default:   w_waiting  = 1'b0;
    endcase
  end

  assign w_abort = w_waiting & w_expired & ~w_progress;

  function automatic logic [1:0] map_err(input logic [1:0] resp);
    logic [1:0] e;
    case (resp)
      2'b10:   e = 2'd1;
      2'b11:   e = 2'd2;
      default: e = 2'd0;
    endcase
    return e;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_req_ready <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end else if (w_abort) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b1;
      r_rready    <= 1'b1;
      r_rsp_err   <= 2'd3;
      r_rsp_rdata <= '0;
      r_timer     <= '0;
      r_state     <= S_DRAIN;
    end else begin
      if (w_waiting) r_timer <= r_timer + TW'(1);
      unique case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_timer     <= '0;
            if (req_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_AW_W;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_AR;
            end
          end
        end
        S_WR_AW_W: begin
          if (w_aw_hs && w_w_hs) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_B;
          end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_state   <= S_WR_W;
          end else if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_state  <= S_WR_AW;
          end
        end
        S_WR_AW: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_B;
          end
        end
        S_WR_W: begin
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_err   <= map_err(m_bresp);
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RD_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_err   <= map_err(m_rresp);
            r_rsp_rdata <= m_rresp[1] ? '0 : m_rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (m_bvalid || m_rvalid || r_timer == TMAX) begin
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign m_awaddr  = r_addr;
  assign m_awprot  = PROT;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_addr;
  assign m_arprot  = PROT;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

endmodule

// File: tb/tb_axi4_lite_req_manager.sv
// Bench for axi4_lite_req_manager: delay-configurable subordinate, transaction
// scoreboard with per-cycle checks, and directed timing expectations.
module tb_axi4_lite_req_manager;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam logic [2:0] PR = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic rsp_ready = 1'b1;
  logic req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0] m_awprot, m_arprot;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic [DW-1:0] m_rdata = '0;

  axi4_lite_req_manager #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .PROT(PR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Subordinate behaviour for the next transaction
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit ar_never = 0;
  logic [1:0] c_bresp = '0, c_rresp = '0;
  logic [DW-1:0] c_rdata = '0;

  task automatic cfg(input int awd, input int wd, input int ard,
                     input int bd, input int rd, input bit arn,
                     input logic [1:0] br, input logic [1:0] rr,
                     input logic [DW-1:0] rdat);
    aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
    ar_never = arn; c_bresp = br; c_rresp = rr; c_rdata = rdat;
  endtask

  typedef struct {
    bit write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0] err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0] err;
    logic [DW-1:0] rdata;
    int t_aw, t_b, t_rsp;
    int aw_hi, w_hi, ar_hi, drain;
    int aw_hs, w_hs, acc;
  } st_t;

  // Transaction outcome from the subordinate's configured latencies
  function automatic exp_t model(input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d,
                                 input logic [SW-1:0] s);
    exp_t e;
    int t;
    bit tmo;
    logic [1:0] resp;
    if (wr) begin
      t = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1 + b_dly + 1;
      tmo = t > TO;
      resp = c_bresp;
    end else begin
      t = ar_dly + 1 + r_dly + 1;
      tmo = ar_never || t > TO;
      resp = c_rresp;
    end
    e.write = wr; e.addr = a; e.wdata = d; e.wstrb = s;
    if (tmo) e.err = 2'd3;
    else if (resp == 2'b10) e.err = 2'd1;
    else if (resp == 2'b11) e.err = 2'd2;
    else e.err = 2'd0;
    e.rdata = (!wr && e.err == 2'd0) ? c_rdata : '0;
    return e;
  endfunction

  exp_t q[$];
  st_t cur;
  st_t hist[64];
  int nrsp = 0;
  bit busy = 0, started = 0, rstchk = 0;
  int since = 0, rel = 0;
  bit aw_done, w_done, ar_done, b_iss, r_iss;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic p_rst = 1'b0, p_reqv = 1'b0, p_reqr = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wd = '0;
  logic [SW-1:0] p_ws = '0;
  logic p_rspv = 1'b0, p_rspr = 1'b0;
  logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr_r = 1'b0;
  logic p_arv = 1'b0, p_arr = 1'b0, p_bv = 1'b0, p_br = 1'b0;
  logic p_rv = 1'b0, p_rr = 1'b0;

  task automatic sub_clear();
    aw_done = 0; w_done = 0; ar_done = 0; b_iss = 0; r_iss = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    m_bvalid = 1'b0; m_rvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    rstchk = 0;
    if (!p_rst) begin
      busy = 0; q.delete(); since = 0; started = 1; rstchk = 1;
      sub_clear();
    end else begin
      since++;
      if (busy) rel++;
      if (p_rspv && p_rspr) begin
        chk("rsp_expected", busy, 1);
        if (busy) begin
          hist[nrsp] = cur;
          nrsp++;
          void'(q.pop_front());
          busy = 0;
        end
      end
      if (p_reqv && p_reqr) begin
        q.push_back(model(p_wr, p_addr, p_wd, p_ws));
        busy = 1; rel = 1;
        cur = '{err: '0, rdata: '0, acc: cyc, default: 0};
        sub_clear();
      end
      if (p_awv && p_awr) begin aw_done = 1; cur.aw_hs++; end
      if (p_wv && p_wr_r) begin w_done = 1; cur.w_hs++; end
      if (p_arv && p_arr) ar_done = 1;
      if (p_bv && p_br) m_bvalid = 1'b0;
      if (p_rv && p_rr) m_rvalid = 1'b0;
    end

    if (started) begin
      if (rstchk)
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_rdata, rsp_err, m_awvalid,
             m_wvalid, m_bready, m_arvalid, m_rready}, 0);
      chk("req_ready", req_ready, (since >= 1 && !busy));
      if (!busy) begin
        chk("idle_outputs",
            {rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid,
             m_rready}, 0);
      end else begin
        chk("prot", {m_awprot, m_arprot}, {PR, PR});
        if (rsp_valid)
          chk("rsp_payload", {rsp_err, rsp_rdata},
              {q[0].err, q[0].rdata});
        if (m_awvalid) chk("awaddr", m_awaddr, q[0].addr);
        if (m_wvalid)
          chk("wdata_wstrb", {m_wdata, m_wstrb},
              {q[0].wdata, q[0].wstrb});
        if (m_arvalid) chk("araddr", m_araddr, q[0].addr);
        if (m_awvalid) begin
          cur.aw_hi++;
          if (cur.t_aw == 0) cur.t_aw = rel;
        end
        if (m_wvalid) cur.w_hi++;
        if (m_arvalid) cur.ar_hi++;
        if (m_bready && !m_rready && cur.t_b == 0) cur.t_b = rel;
        if (m_bready && m_rready) cur.drain++;
        if (rsp_valid) begin
          if (cur.t_rsp == 0) cur.t_rsp = rel;
          cur.err = rsp_err;
          cur.rdata = rsp_rdata;
        end
      end
    end

    m_awready = m_awvalid && (aw_wait >= aw_dly);
    if (m_awvalid) aw_wait++;
    m_wready = m_wvalid && (w_wait >= w_dly);
    if (m_wvalid) w_wait++;
    m_arready = m_arvalid && !ar_never && (ar_wait >= ar_dly);
    if (m_arvalid) ar_wait++;
    if (aw_done && w_done && !b_iss) begin
      if (b_wait >= b_dly) begin
        m_bvalid = 1'b1; m_bresp = c_bresp; b_iss = 1;
      end else b_wait++;
    end
    if (ar_done && !r_iss) begin
      if (r_wait >= r_dly) begin
        m_rvalid = 1'b1; m_rresp = c_rresp; m_rdata = c_rdata; r_iss = 1;
      end else r_wait++;
    end

    p_rst = rst_n; p_reqv = req_valid; p_reqr = req_ready;
    p_wr = req_write; p_addr = req_addr; p_wd = req_wdata; p_ws = req_wstrb;
    p_rspv = rsp_valid; p_rspr = rsp_ready;
    p_awv = m_awvalid; p_awr = m_awready;
    p_wv = m_wvalid; p_wr_r = m_wready;
    p_arv = m_arvalid; p_arr = m_arready;
    p_bv = m_bvalid; p_br = m_bready;
    p_rv = m_rvalid; p_rr = m_rready;
  end

  task automatic send(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit acc, ok;
    ok = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a;
    req_wdata = d; req_wstrb = s;
    for (int i = 0; i < 200; i++) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    if (!ok) chk("accept_wait", 0, 1);
    req_valid = 1'b0; req_write = ~wr;
    req_addr = a ^ 32'hBAD0_0000; req_wdata = ~d; req_wstrb = ~s;
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (nrsp >= target) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("rsp_wait", nrsp, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n0;
  bit seen;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D);
    n0 = nrsp;
    send(1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    send(0, 32'h2000, 32'h0, 4'h0);
    wait_rsp(n0 + 2);
    chk("wr0_t_aw", hist[n0].t_aw, 1);
    chk("wr0_t_bready", hist[n0].t_b, 2);
    chk("wr0_t_rsp", hist[n0].t_rsp, 3);
    chk("wr0_err_rdata", {hist[n0].err, hist[n0].rdata}, 0);
    chk("wr0_aw_w_beats", {hist[n0].aw_hs, hist[n0].w_hs}, {32'd1, 32'd1});
    chk("rd0_rdata", hist[n0+1].rdata, 32'hCAFE_F00D);
    chk("throughput", hist[n0+1].acc - hist[n0].acc, 4);

    cfg(0, 0, 2, 0, 2, 0, 2'b00, 2'b00, 32'h1234_5678);
    n0 = nrsp;
    send(0, 32'h3000, 32'h0, 4'h0);
    wait_rsp(n0 + 1);
    chk("rd_slow_rdata", hist[n0].rdata, 32'h1234_5678);
    chk("rd_slow_err", hist[n0].err, 0);
    chk("rd_slow_ar_cycles", hist[n0].ar_hi, 3);
    chk("rd_slow_t_rsp", hist[n0].t_rsp, 7);

    cfg(2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    n0 = nrsp;
    send(1, 32'h1004, 32'h0BAD_F00D, 4'h3);
    wait_rsp(n0 + 1);
    chk("wr_split_w_cycles", hist[n0].w_hi, 1);
    chk("wr_split_aw_cycles", hist[n0].aw_hi, 3);
    chk("wr_split_beats", {hist[n0].aw_hs, hist[n0].w_hs}, {32'd1, 32'd1});
    chk("wr_split_t_bready", hist[n0].t_b, 4);

    n0 = nrsp;
    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h5555_AAAA);
    send(0, 32'h4000, 32'h0, 4'h0);
    wait_rsp(n0 + 1);
    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h5555_AAAA);
    send(0, 32'h4004, 32'h0, 4'h0);
    wait_rsp(n0 + 2);
    cfg(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0);
    send(1, 32'h4008, 32'h1, 4'h1);
    wait_rsp(n0 + 3);
    chk("slverr", {hist[n0].err, hist[n0].rdata}, {2'd1, 32'h0});
    chk("decerr", {hist[n0+1].err, hist[n0+1].rdata}, {2'd2, 32'h0});
    chk("exokay_write", hist[n0+2].err, 0);

    cfg(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0);
    n0 = nrsp;
    send(0, 32'h5000, 32'h0, 4'h0);
    wait_rsp(n0 + 1);
    chk("tmo_err", {hist[n0].err, hist[n0].rdata}, {2'd3, 32'h0});
    chk("tmo_ar_cycles", hist[n0].ar_hi, 8);
    chk("tmo_drain_cycles", hist[n0].drain, 8);
    chk("tmo_t_rsp", hist[n0].t_rsp, 17);
    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h7777_0001);
    send(0, 32'h5004, 32'h0, 4'h0);
    wait_rsp(n0 + 2);
    chk("after_tmo_rdata", hist[n0+1].rdata, 32'h7777_0001);

    cfg(0, 0, 0, 8, 0, 0, 2'b00, 2'b00, 32'h0);
    n0 = nrsp;
    send(1, 32'h6000, 32'h6, 4'hF);
    wait_rsp(n0 + 1);
    chk("late_b_err", hist[n0].err, 3);
    chk("late_b_drain", hist[n0].drain, 2);

    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_A5A5);
    rsp_ready = 1'b0;
    n0 = nrsp;
    send(0, 32'h7000, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("bp_rsp_seen", seen, 1);
    cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h7004;
    req_wdata = 32'h0000_0042; req_wstrb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", req_ready, 0);
      chk("bp_payload", {rsp_valid, rsp_err, rsp_rdata},
          {1'b1, 2'd0, 32'h0000_A5A5});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    send(1, 32'h7004, 32'h0000_0042, 4'h1);
    wait_rsp(n0 + 2);
    chk("bp_second_err", hist[n0+1].err, 0);

    cfg(0, 0, 0, 20, 0, 0, 2'b00, 2'b00, 32'h0);
    n0 = nrsp;
    send(1, 32'h8000, 32'h8, 4'hF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_bready) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("rst_wr_b_reached", seen, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("rst_no_rsp", nrsp, n0);
    chk("rst_req_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
